// File: rtl/video_pkg.sv
// Shared types for the video timing meter: default measurement width and the published timing record.
package video_pkg;

    localparam int VID_W = 12;

    typedef struct packed {
        logic [VID_W-1:0] hact;
        logic [VID_W-1:0] htotal;
        logic [VID_W-1:0] vact;
        logic [VID_W-1:0] vtotal;
    } timing_t;

endpackage

// File: rtl/vtm_line_counter.sv
// Per-line pixel and active-pixel counters with hs rise detection; counters saturate and flag overflow.
module vtm_line_counter
    import video_pkg::*;
#(
    parameter int W = VID_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         hs,
    input  logic         de,
    output logic         line_done,
    output logic [W-1:0] line_len,
    output logic [W-1:0] line_act,
    output logic         line_ovf
);
    localparam logic [W-1:0] CMAX = '1;

    logic         hs_q;
    logic         ovf_q;
    logic [W-1:0] hcnt;
    logic [W-1:0] dcnt;

    assign line_done = ce && hs && !hs_q;
    assign line_len  = (hcnt == CMAX) ? CMAX : hcnt + 1'b1;
    assign line_act  = dcnt;
    // a line whose length no longer fits is flagged even before it closes
    assign line_ovf  = ovf_q || (hcnt == CMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b0;
            ovf_q <= 1'b0;
            hcnt  <= '0;
            dcnt  <= '0;
        end else if (ce) begin
            hs_q <= hs;
            if (line_done) begin
                hcnt  <= '0;
                dcnt  <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (hcnt == CMAX) ovf_q <= 1'b1;
                else              hcnt  <= hcnt + 1'b1;
                if (de) begin
                    if (dcnt == CMAX) ovf_q <= 1'b1;
                    else              dcnt  <= dcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/video_timing_meter.sv
// Measures active/total width and lines per frame and publishes the mode once stable for STABLE_FRAMES frames.
// Define VIDEO_TIMING_METER_INTERLACE_EN to accept alternating N/N+1 line fields as one interlaced mode.
module video_timing_meter
    import video_pkg::*;
#(
    parameter int          W             = VID_W,
    parameter int          STABLE_FRAMES = 2,
    parameter logic [23:0] TIMEOUT       = 24'd4000000
) (
    input  logic         clk_vid,
    input  logic         reset_n,
    input  logic         ce_pix,
    input  logic         hs,
    input  logic         vs,
    input  logic         de,
    output logic [W-1:0] hact,
    output logic [W-1:0] htotal,
    output logic [W-1:0] vact,
    output logic [W-1:0] vtotal,
    output logic         valid,
    output logic         changed,
    output logic         interlaced
);
    localparam logic [W-1:0] CMAX = '1;
    localparam logic [3:0]   SF   = 4'(STABLE_FRAMES);

    logic         line_done;
    logic         line_ovf;
    logic [W-1:0] line_len;
    logic [W-1:0] line_act;

    vtm_line_counter #(.W(W)) u_line (
        .clk       (clk_vid),
        .rst_n     (reset_n),
        .ce        (ce_pix),
        .hs        (hs),
        .de        (de),
        .line_done (line_done),
        .line_len  (line_len),
        .line_act  (line_act),
        .line_ovf  (line_ovf)
    );

    logic         vs_q;
    logic         started;
    logic         frame_ovf;
    logic [W-1:0] hact_max;
    logic [W-1:0] len_q;
    logic [W-1:0] vact_cnt;
    logic [W-1:0] vtot_cnt;
    logic [3:0]   stable_cnt;
    logic [23:0]  tcnt;
    timing_t      prev;
    timing_t      pub;

    logic         vs_rise;
    logic         tmo_hit;
    logic [W-1:0] hmax_n;
    logic [W-1:0] len_n;
    logic [W-1:0] vact_n;
    logic [W-1:0] vtot_n;
    logic         ovf_n;
    timing_t      cand;
    timing_t      next_pub;
    logic         frame_bad;
    logic         eq_rest;
    logic         il_pair;
    logic         match;
    logic         publish;
    logic [3:0]   stable_n;

    assign vs_rise = ce_pix && vs && !vs_q;
    assign tmo_hit = !vs_rise && (tcnt == TIMEOUT - 24'd1);

    // Accumulator values including a line that closes on this very sample, so a
    // coincident hs/vs rise lands the closing line in the ending frame.
    always_comb begin
        hmax_n = hact_max;
        len_n  = len_q;
        vact_n = vact_cnt;
        vtot_n = vtot_cnt;
        ovf_n  = frame_ovf;
        if (line_done) begin
            if (line_act > hact_max) hmax_n = line_act;
            len_n = line_len;
            ovf_n = frame_ovf || line_ovf;
            if (line_act != '0) begin
                if (vact_cnt == CMAX) ovf_n  = 1'b1;
                else                  vact_n = vact_cnt + 1'b1;
            end
            if (vtot_cnt == CMAX) ovf_n  = 1'b1;
            else                  vtot_n = vtot_cnt + 1'b1;
        end
    end

    always_comb begin
        cand.hact   = hmax_n;
        cand.htotal = len_n;
        cand.vact   = vact_n;
        cand.vtotal = vtot_n;
        frame_bad   = ovf_n || line_ovf;
        eq_rest     = (cand.hact == prev.hact) && (cand.htotal == prev.htotal) &&
                      (cand.vact == prev.vact);
`ifdef VIDEO_TIMING_METER_INTERLACE_EN
        il_pair     = eq_rest && ((cand.vtotal == prev.vtotal + 1'b1) ||
                                  (prev.vtotal == cand.vtotal + 1'b1));
`else
        il_pair     = 1'b0;
`endif
        match       = !frame_bad && eq_rest && ((cand.vtotal == prev.vtotal) || il_pair);
        next_pub    = cand;
        if (il_pair && (prev.vtotal > cand.vtotal)) next_pub.vtotal = prev.vtotal;
        stable_n    = match ? ((stable_cnt >= SF) ? SF : stable_cnt + 4'd1) : 4'd1;
        publish     = (stable_n == SF) && !frame_bad;
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            vs_q       <= 1'b0;
            started    <= 1'b0;
            frame_ovf  <= 1'b0;
            hact_max   <= '0;
            len_q      <= '0;
            vact_cnt   <= '0;
            vtot_cnt   <= '0;
            stable_cnt <= '0;
            tcnt       <= '0;
            prev       <= '0;
            pub        <= '0;
            valid      <= 1'b0;
            changed    <= 1'b0;
            interlaced <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (ce_pix) vs_q <= vs;

            if (vs_rise)               tcnt <= '0;
            else if (tcnt != TIMEOUT)  tcnt <= tcnt + 24'd1;

            if (vs_rise) begin
                hact_max  <= '0;
                len_q     <= '0;
                vact_cnt  <= '0;
                vtot_cnt  <= '0;
                frame_ovf <= 1'b0;
                started   <= 1'b1;
                if (started) begin
                    prev       <= cand;
                    stable_cnt <= stable_n;
                    if (publish) begin
                        pub        <= next_pub;
                        valid      <= 1'b1;
                        interlaced <= il_pair;
                        changed    <= !valid || (next_pub != pub) || (il_pair != interlaced);
                    end else if (!match) begin
                        valid <= 1'b0;
                    end
                end
            end else if (line_done) begin
                hact_max  <= hmax_n;
                len_q     <= len_n;
                vact_cnt  <= vact_n;
                vtot_cnt  <= vtot_n;
                frame_ovf <= ovf_n;
            end

            if (tmo_hit) begin
                valid      <= 1'b0;
                pub        <= '0;
                interlaced <= 1'b0;
                stable_cnt <= '0;
                started    <= 1'b0;
                changed    <= valid;
            end
        end
    end

    assign hact   = pub.hact;
    assign htotal = pub.htotal;
    assign vact   = pub.vact;
    assign vtotal = pub.vtotal;

endmodule
